// File: rtl/mem_copy_dma_pkg.sv
// Shared types and default widths for the memory-to-memory copy DMA.
package mem_copy_dma_pkg;

  localparam int unsigned DefAddrW = 16;
  localparam int unsigned DefDataW = 8;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StRead,
    StWrite,
    StDone
  } dma_state_e;

endpackage

// File: rtl/mem_copy_dma.sv
// Byte-wise forward memory copy engine that borrows the CPU memory bus.
// Optional fill mode (constant pattern, one cycle per byte) is built when MEM_COPY_FILL_EN is defined.
module mem_copy_dma
  import mem_copy_dma_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
`ifdef MEM_COPY_FILL_EN
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_value,
`endif
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_cs,
  output logic              mem_we
);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              fill_mode;
  logic [DATA_W-1:0] wr_data;

`ifdef MEM_COPY_FILL_EN
  logic              fill_q;
  logic [DATA_W-1:0] fill_val_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q     <= 1'b0;
      fill_val_q <= '0;
    end else if (state_q == StIdle && start) begin
      fill_q     <= fill;
      fill_val_q <= fill_value;
    end
  end

  assign fill_mode = fill_q;
  assign wr_data   = fill_q ? fill_val_q : data_q;
`else
  assign fill_mode = 1'b0;
  assign wr_data   = data_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    busy      = (state_q != StIdle);
    done      = 1'b0;
    bus_req   = 1'b0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          cnt_d   = length;
          state_d = (length == '0) ? StDone : StReq;
        end
      end
      StReq: begin
        bus_req = 1'b1;
        if (bus_gnt) state_d = fill_mode ? StWrite : StRead;
      end
      // Bus strobes are qualified by the grant so a lost grant never touches memory;
      // the byte is retried from REQ once the bus comes back.
      StRead: begin
        bus_req  = 1'b1;
        mem_addr = src_q;
        mem_cs   = bus_gnt;
        if (bus_gnt) begin
          data_d  = mem_rdata;
          state_d = StWrite;
        end else begin
          state_d = StReq;
        end
      end
      StWrite: begin
        bus_req   = 1'b1;
        mem_addr  = dst_q;
        mem_wdata = wr_data;
        mem_cs    = bus_gnt;
        mem_we    = bus_gnt;
        if (bus_gnt) begin
          src_d = src_q + 1'b1;
          dst_d = dst_q + 1'b1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == ADDR_W'(1)) state_d = StDone;
          else                     state_d = fill_mode ? StWrite : StRead;
        end else begin
          state_d = StReq;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort leaves any write strobe of this cycle intact but suppresses the done pulse.
    if (abort && state_q != StIdle) begin
      state_d = StIdle;
      done    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma: directed scenarios plus randomized copies
// compared against a byte-array reference model.
module tb_mem_copy_dma;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          bus_gnt;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [AW-1:0] length;
  logic          busy;
  logic          done;
  logic          bus_req;
  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef MEM_COPY_FILL_EN
  logic          fill;
  logic [DW-1:0] fill_value;
`endif

  logic [DW-1:0] mem   [65536];
  logic [DW-1:0] model [65536];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;
  int            wr_cnt = 0;
  int            rd_cnt = 0;
  logic [AW-1:0] rd_log [256];
  int            n_checks = 0;
  int            n_pass = 0;

  always #5 clk = ~clk;

  mem_copy_dma dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .length    (length),
`ifdef MEM_COPY_FILL_EN
    .fill      (fill),
    .fill_value(fill_value),
`endif
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .bus_req   (bus_req),
    .bus_gnt   (bus_gnt),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (mem_cs && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
    end
    if (mem_cs && !mem_we) begin
      rd_log[rd_cnt[7:0]] <= mem_addr;
      rd_cnt              <= rd_cnt + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_data = v;
    tick();
    bd_we    = 1'b0;
    model[a] = v;
  endtask

  // Random source bytes plus one guard byte past the destination window.
  task automatic prep(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
    logic [AW-1:0] a;
    a = s;
    for (int i = 0; i < n; i++) begin
      poke(a, DW'($urandom));
      a++;
    end
    a = d;
    for (int i = 0; i <= n; i++) begin
      poke(a, DW'($urandom));
      a++;
    end
  endtask

  task automatic apply_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    a = s;
    b = d;
    for (int i = 0; i < n; i++) begin
      model[b] = model[a];
      a++;
      b++;
    end
  endtask

  task automatic verify(input string tag, input logic [AW-1:0] d, input int n);
    logic [AW-1:0] b;
    b = d;
    for (int i = 0; i < n; i++) begin
      check(tag, 32'(mem[b]), 32'(model[b]));
      b++;
    end
  endtask

  // Launch a transfer; optionally drop the grant, abort, or reset after a given number of writes.
  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW-1:0] n,
                          input int drop_after, input int drop_len, input int stop_after,
                          input bit use_rst, output int lat, output int n_done,
                          output bit breq_seen);
    int w0;
    int c;
    int first_op;
    int hold;
    int nw;
    bit dropped;
    bit stopping;
    w0 = wr_cnt;
    first_op = -1;
    hold = 0;
    dropped = 1'b0;
    stopping = 1'b0;
    lat = -1;
    n_done = 0;
    breq_seen = 1'b0;
    src_addr = s;
    dst_addr = d;
    length = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 1;
    while (c < 4 * int'(n) + 64) begin
      nw = wr_cnt - w0;
      if (bus_req) breq_seen = 1'b1;
      if (mem_cs && first_op < 0) first_op = c;
      if (done) begin
        n_done++;
        lat = (first_op < 0) ? c : c - first_op;
        break;
      end
      if (stopping) break;
      // A start while busy carries bogus parameters; it must be ignored.
      if (c == 3) begin
        start = 1'b1;
        src_addr = ~s;
        dst_addr = ~d;
        length = 1;
      end else begin
        start = 1'b0;
      end
      if (stop_after >= 0 && nw == stop_after) begin
        stopping = 1'b1;
        if (use_rst) rst_n = 1'b0;
        else abort = 1'b1;
      end
      if (!dropped && drop_after >= 0 && nw == drop_after) begin
        bus_gnt = 1'b0;
        dropped = 1'b1;
        hold = drop_len;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) bus_gnt = 1'b1;
      end
      tick();
      c++;
    end
    start = 1'b0;
    abort = 1'b0;
    bus_gnt = 1'b1;
  endtask

  initial begin
    int            lat;
    int            nd;
    bit            bs;
    int            w0;
    int            r0;
    int            n;
    int            da;
    int            dl;
    logic [AW-1:0] s;
    logic [AW-1:0] d;

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    bus_gnt = 1'b1;
    src_addr = '0;
    dst_addr = '0;
    length = '0;
    bd_we = 1'b0;
    bd_addr = '0;
    bd_data = '0;
`ifdef MEM_COPY_FILL_EN
    fill = 1'b0;
    fill_value = '0;
`endif
    repeat (2) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_bus_req", 32'(bus_req), 0);
    check("rst_mem_cs", 32'(mem_cs), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    rst_n = 1'b1;
    tick();

    // Basic four-byte copy.
    prep(16'h0010, 16'h0080, 4);
    poke(16'h0010, 8'hAA);
    poke(16'h0011, 8'hBB);
    poke(16'h0012, 8'hCC);
    poke(16'h0013, 8'hDD);
    w0 = wr_cnt;
    run_copy(16'h0010, 16'h0080, 4, -1, 0, -1, 1'b0, lat, nd, bs);
    apply_copy(16'h0010, 16'h0080, 4);
    check("basic_done", 32'(nd), 1);
    check("basic_latency", 32'(lat), 8);
    check("basic_busy_at_done", 32'(busy), 1);
    check("basic_byte0", 32'(mem[16'h0080]), 32'h00AA);
    verify("basic_bytes", 16'h0080, 5);
    tick();
    check("basic_busy_after", 32'(busy), 0);
    check("basic_writes", 32'(wr_cnt - w0), 4);

    // Zero length: immediate done, no bus request, no write.
    w0 = wr_cnt;
    run_copy(16'h0020, 16'h0030, 0, -1, 0, -1, 1'b0, lat, nd, bs);
    check("len0_done", 32'(nd), 1);
    check("len0_latency", 32'(lat), 1);
    check("len0_bus_req", 32'(bs), 0);
    tick();
    check("len0_writes", 32'(wr_cnt - w0), 0);
    check("len0_busy_after", 32'(busy), 0);

    // Source address wrap.
    prep(16'hFFFE, 16'h0040, 3);
    r0 = rd_cnt;
    run_copy(16'hFFFE, 16'h0040, 3, -1, 0, -1, 1'b0, lat, nd, bs);
    apply_copy(16'hFFFE, 16'h0040, 3);
    check("wrap_done", 32'(nd), 1);
    check("wrap_latency", 32'(lat), 6);
    check("wrap_rd0", 32'(rd_log[r0[7:0]]), 32'h0000_FFFE);
    r0++;
    check("wrap_rd1", 32'(rd_log[r0[7:0]]), 32'h0000_FFFF);
    r0++;
    check("wrap_rd2", 32'(rd_log[r0[7:0]]), 32'h0000_0000);
    verify("wrap_bytes", 16'h0040, 4);
    tick();

    // Grant lost for three cycles after the first byte.
    prep(16'h0200, 16'h0300, 4);
    w0 = wr_cnt;
    run_copy(16'h0200, 16'h0300, 4, 1, 3, -1, 1'b0, lat, nd, bs);
    apply_copy(16'h0200, 16'h0300, 4);
    check("gnt_done", 32'(nd), 1);
    check("gnt_latency_grew", 32'(lat >= 11), 1);
    verify("gnt_bytes", 16'h0300, 5);
    tick();
    check("gnt_writes", 32'(wr_cnt - w0), 4);

    // Abort after two bytes.
    prep(16'h0400, 16'h0500, 4);
    w0 = wr_cnt;
    run_copy(16'h0400, 16'h0500, 4, -1, 0, 2, 1'b0, lat, nd, bs);
    apply_copy(16'h0400, 16'h0500, 2);
    check("abort_no_done", 32'(nd), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_writes", 32'(wr_cnt - w0), 2);
    verify("abort_bytes", 16'h0500, 5);
    tick();
    check("abort_stays_idle", 32'(busy), 0);

    // Reset after two bytes.
    prep(16'h0600, 16'h0700, 4);
    w0 = wr_cnt;
    run_copy(16'h0600, 16'h0700, 4, -1, 0, 2, 1'b1, lat, nd, bs);
    apply_copy(16'h0600, 16'h0700, 2);
    check("rst_mid_no_done", 32'(nd), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_bus_req", 32'(bus_req), 0);
    rst_n = 1'b1;
    tick();
    check("rst_mid_writes", 32'(wr_cnt - w0), 2);
    verify("rst_mid_bytes", 16'h0700, 5);

    // Randomized copies, some overlapping forward, some with grant loss.
    for (int k = 0; k < 10; k++) begin
      n = int'($urandom_range(1, 12));
      s = AW'($urandom);
      if (k % 3 == 0) d = s + AW'($urandom_range(1, n));
      else d = AW'($urandom);
      if (k % 2 == 1) begin
        da = int'($urandom_range(0, n - 1));
        dl = int'($urandom_range(1, 4));
      end else begin
        da = -1;
        dl = 0;
      end
      prep(s, d, n);
      w0 = wr_cnt;
      run_copy(s, d, AW'(n), da, dl, -1, 1'b0, lat, nd, bs);
      apply_copy(s, d, n);
      check("rand_done", 32'(nd), 1);
      if (da < 0) check("rand_latency", 32'(lat), 32'(2 * n));
      else check("rand_latency_min", 32'(lat >= 2 * n), 1);
      verify("rand_bytes", d, n + 1);
      tick();
      check("rand_writes", 32'(wr_cnt - w0), 32'(n));
    end

`ifdef MEM_COPY_FILL_EN
    // Pattern fill: one cycle per byte, no reads.
    prep(16'h0000, 16'h0100, 16);
    fill = 1'b1;
    fill_value = 8'h5A;
    r0 = rd_cnt;
    run_copy(16'h0000, 16'h0100, 16, -1, 0, -1, 1'b0, lat, nd, bs);
    fill = 1'b0;
    for (int i = 0; i < 16; i++) model[16'h0100 + 16'(i)] = 8'h5A;
    check("fill_done", 32'(nd), 1);
    check("fill_latency", 32'(lat), 16);
    check("fill_no_reads", 32'(rd_cnt - r0), 0);
    verify("fill_bytes", 16'h0100, 17);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
